// File: rtl/itoa_pkg.sv
// Shared constants, state encoding and sizing helper for the integer-to-ASCII converter.
package itoa_pkg;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_ZERO  = 8'h30;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_OVF   = 8'h2A;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  // Character index must be able to count 0..NCHAR inclusive.
  function automatic int idx_width(input int nchar);
    return $clog2(nchar + 1);
  endfunction

endpackage

// File: rtl/itoa_multi_if.sv
// Request/result handshake bundle between the converter and its producer/consumer.
interface itoa_multi_if #(
  parameter int WIDTH = 16,
  parameter int NCHAR = 6
);

  logic                  i_valid;
  logic                  i_ready;
  logic [WIDTH-1:0]      i_val;
  logic                  i_signed;
  logic                  i_zpad;
  logic                  o_valid;
  logic                  o_ready;
  logic                  o_ovf;
  logic [NCHAR-1:0][7:0] o_str;

  modport slave (
    input  i_valid, i_val, i_signed, i_zpad, o_ready,
    output i_ready, o_valid, o_ovf, o_str
  );

  modport master (
    output i_valid, i_val, i_signed, i_zpad, o_ready,
    input  i_ready, o_valid, o_ovf, o_str
  );

endinterface

// File: rtl/itoa_multi_divmod10.sv
// Combinational unsigned divide-by-ten: restoring long division, one quotient bit per stage.
module divmod10 #(
  parameter int W = 17
) (
  input  logic [W-1:0] din,
  output logic [W-1:0] quo,
  output logic [3:0]   rem
);

  logic [4:0] part;

  always_comb begin
    // NOTE: combinational blocks use blocking assignments, and every output
    // gets a default at the top so no path can leave it unassigned (latch).
    part = '0;
    quo  = '0;
    for (int i = W - 1; i >= 0; i--) begin
      part = {part[3:0], din[i]};
      if (part >= 5'd10) begin
        part   = part - 5'd10;
        quo[i] = 1'b1;
      end
    end
    rem = part[3:0];
  end

endmodule

// File: rtl/itoa_multi.sv
// Multi-cycle integer-to-decimal-ASCII converter: one character per cycle, right to left,
// with sign placement, optional zero padding, overflow fill and output back-pressure.
module itoa_multi
  import itoa_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NCHAR = 6
) (
  input logic         clk,
  input logic         rstn,
  itoa_multi_if.slave bus
);

  localparam int IW = idx_width(NCHAR);
  localparam int MW = WIDTH + 1;

  if (WIDTH < 2 || WIDTH > 32 || NCHAR < 2 || NCHAR > 11) begin : g_bad_params
    $error("itoa_multi: WIDTH must be 2..32 and NCHAR 2..11");
  end

  state_t                state, state_nxt;
  logic [MW-1:0]         mag, quo;
  logic [3:0]            rem;
  logic                  neg, zpad, sign_placed;
  logic [IW-1:0]         idx, pos;
  logic [NCHAR-1:0][7:0] str;
  logic                  ovf;

  logic                  accept, idx_last, last_char;
  logic                  place_sign, ovf_nxt;
  logic [7:0]            ch;
  logic                  neg_in;
  logic [MW-1:0]         ext_in, mag_in;

  divmod10 #(.W(MW)) u_divmod10 (
    .din (mag),
    .quo (quo),
    .rem (rem)
  );

  // The extra magnitude bit lets the most-negative two's complement value negate exactly.
  assign neg_in = bus.i_signed & bus.i_val[WIDTH-1];
  assign ext_in = {neg_in, bus.i_val};
  assign mag_in = neg_in ? (~ext_in + MW'(1)) : ext_in;

  assign accept    = bus.i_valid & bus.i_ready;
  assign idx_last  = (idx == IW'(NCHAR - 1));
  assign last_char = (state == CONV) & idx_last;
  assign pos       = IW'(NCHAR - 1) - idx;

  always_comb begin
    state_nxt   = state;
    bus.i_ready = 1'b0;
    bus.o_valid = 1'b0;
    unique case (state)
      IDLE: begin
        bus.i_ready = 1'b1;
        if (bus.i_valid) state_nxt = CONV;
      end
      CONV: begin
        if (last_char) state_nxt = DONE;
      end
      DONE: begin
        bus.o_valid = 1'b1;
        bus.i_ready = bus.o_ready;
        // A request arriving with the consuming edge restarts conversion without a bubble.
        if (bus.o_ready) state_nxt = bus.i_valid ? CONV : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Character for the current position; the rightmost one is always a digit so zero prints "0".
  always_comb begin
    ch         = CH_ZERO + {4'h0, rem};
    place_sign = 1'b0;
    if (idx != '0 && mag == '0) begin
      if (zpad) begin
        if (neg && idx_last) begin
          ch         = CH_MINUS;
          place_sign = 1'b1;
        end else begin
          ch = CH_ZERO;
        end
      end else if (neg && !sign_placed) begin
        ch         = CH_MINUS;
        place_sign = 1'b1;
      end else begin
        ch = CH_SPACE;
      end
    end
  end

  // Digits left over, or a sign that never found room, mean the value did not fit.
  assign ovf_nxt = (quo != '0) | (neg & ~(sign_placed | place_sign));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mag         <= '0;
      neg         <= 1'b0;
      zpad        <= 1'b0;
      sign_placed <= 1'b0;
      idx         <= '0;
      ovf         <= 1'b0;
      // NOTE: the character register is a handful of flops visible on the port,
      // not a RAM, so it is reset to a defined blank field.
      str         <= {NCHAR{CH_SPACE}};
    end else if (accept) begin
      mag         <= mag_in;
      neg         <= neg_in;
      zpad        <= bus.i_zpad;
      sign_placed <= 1'b0;
      idx         <= '0;
      ovf         <= 1'b0;
    end else if (state == CONV) begin
      mag <= quo;
      idx <= idx + IW'(1);
      if (place_sign) sign_placed <= 1'b1;
      if (idx_last && ovf_nxt) begin
        str <= {NCHAR{CH_OVF}};
        ovf <= 1'b1;
      end else begin
        for (int k = 0; k < NCHAR; k++) begin
          if (pos == IW'(k)) str[k] <= ch;
        end
      end
    end
  end

  assign bus.o_str = str;
  assign bus.o_ovf = ovf;

endmodule

// File: tb/tb_itoa_multi.sv
// Directed-vector, sequence and randomised bench for itoa_multi over four WIDTH/NCHAR configurations.
module tb_itoa_multi;
  import itoa_pkg::*;

  localparam int NI = 4;
  localparam int WS [NI] = '{16, 16, 8, 32};
  localparam int NS [NI] = '{6, 4, 3, 11};

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic        d_valid  [NI];
  logic [31:0] d_val    [NI];
  logic        d_signed [NI];
  logic        d_zpad   [NI];
  logic        d_oready [NI];
  logic        q_iready [NI];
  logic        q_ovalid [NI];
  logic        q_ovf    [NI];
  logic [87:0] q_str    [NI];

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    itoa_multi_if #(.WIDTH(WS[g]), .NCHAR(NS[g])) bus ();
    itoa_multi #(.WIDTH(WS[g]), .NCHAR(NS[g])) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
    );
    assign bus.i_valid  = d_valid[g];
    assign bus.i_val    = d_val[g][WS[g]-1:0];
    assign bus.i_signed = d_signed[g];
    assign bus.i_zpad   = d_zpad[g];
    assign bus.o_ready  = d_oready[g];
    assign q_iready[g]  = bus.i_ready;
    assign q_ovalid[g]  = bus.o_valid;
    assign q_ovf[g]     = bus.o_ovf;
    assign q_str[g]     = 88'(bus.o_str);
  end

  task automatic check(input string name, input logic [87:0] act, input logic [87:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [87:0] str_of(input string s);
    logic [87:0] r = '0;
    for (int j = 0; j < s.len(); j++) r[j*8 +: 8] = s[j];
    return r;
  endfunction

  function automatic logic [87:0] fill(input int n, input logic [7:0] c);
    logic [87:0] r = '0;
    for (int j = 0; j < n; j++) r[j*8 +: 8] = c;
    return r;
  endfunction

  // Reference itoa: count decimal digits, decide fit, then lay the field out left to right.
  function automatic void model(input int w, input int n, input logic [31:0] v, input bit sg,
                                input bit zp, output logic [87:0] s, output bit ov);
    longint unsigned u, m, t;
    bit neg;
    int nd;
    u   = longint'(v) & ((64'd1 << w) - 64'd1);
    neg = sg && (((u >> (w - 1)) & 64'd1) != 0);
    m   = neg ? ((64'd1 << w) - u) : u;
    nd  = 0;
    t   = m;
    do begin
      nd++;
      t = t / 10;
    end while (t != 0);
    s  = '0;
    ov = (nd + (neg ? 1 : 0)) > n;
    if (ov) begin
      s = fill(n, CH_OVF);
    end else begin
      t = m;
      for (int j = n - 1; j >= 0; j--) begin
        int from_right = n - 1 - j;
        if (from_right < nd) begin
          s[j*8 +: 8] = 8'h30 + 8'(t % 10);
          t = t / 10;
        end else if (zp) begin
          s[j*8 +: 8] = (neg && j == 0) ? 8'h2D : 8'h30;
        end else begin
          s[j*8 +: 8] = (neg && from_right == nd) ? 8'h2D : 8'h20;
        end
      end
    end
  endfunction

  task automatic run_one(input int k, input logic [31:0] v, input bit sg, input bit zp,
                         output logic [87:0] s, output bit ov, output int lat);
    int cnt = 0;
    @(negedge clk);
    while (!q_iready[k] && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (!q_iready[k]) check("i_ready_timeout", 88'(q_iready[k]), 88'(1));
    d_valid[k]  = 1'b1;
    d_val[k]    = v;
    d_signed[k] = sg;
    d_zpad[k]   = zp;
    @(posedge clk);
    @(negedge clk);
    d_valid[k] = 1'b0;
    lat = 0;
    while (!q_ovalid[k] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    s  = q_str[k];
    ov = q_ovf[k];
  endtask

  typedef struct {
    int          k;
    logic [31:0] v;
    bit          sg;
    bit          zp;
    string       s;
    bit          ovf;
  } vec_t;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [$];
    logic [87:0] s, s_m;
    bit          ov, ov_m;
    int          lat;
    logic [31:0] vals [3];
    logic [87:0] outs [3];
    int          tcyc [3];
    int          nxt, nout;

    tbl.push_back('{0, 32'h8000, 1'b1, 1'b0, "-32768", 1'b0});
    tbl.push_back('{0, 32'h0000, 1'b1, 1'b0, "     0", 1'b0});
    tbl.push_back('{0, 32'hFFFF, 1'b0, 1'b0, " 65535", 1'b0});
    tbl.push_back('{0, 32'hFFD6, 1'b1, 1'b1, "-00042", 1'b0});
    tbl.push_back('{0, 32'h7FFF, 1'b1, 1'b1, "032767", 1'b0});
    tbl.push_back('{1, 32'hFC19, 1'b1, 1'b0, "-999",   1'b0});
    tbl.push_back('{1, 32'hFC18, 1'b1, 1'b0, "****",   1'b1});
    tbl.push_back('{1, 32'h3039, 1'b0, 1'b0, "****",   1'b1});
    tbl.push_back('{1, 32'h270F, 1'b0, 1'b1, "9999",   1'b0});
    tbl.push_back('{1, 32'hFC19, 1'b1, 1'b1, "-999",   1'b0});
    tbl.push_back('{1, 32'hFC18, 1'b1, 1'b1, "****",   1'b1});
    tbl.push_back('{2, 32'h0080, 1'b1, 1'b0, "***",    1'b1});
    tbl.push_back('{2, 32'h00FF, 1'b0, 1'b0, "255",    1'b0});
    tbl.push_back('{2, 32'h009D, 1'b1, 1'b0, "-99",    1'b0});
    tbl.push_back('{3, 32'h80000000, 1'b1, 1'b0, "-2147483648", 1'b0});
    tbl.push_back('{3, 32'hFFFFFFFF, 1'b0, 1'b0, " 4294967295", 1'b0});

    for (int k = 0; k < NI; k++) begin
      d_valid[k]  = 1'b0;
      d_val[k]    = '0;
      d_signed[k] = 1'b0;
      d_zpad[k]   = 1'b0;
      d_oready[k] = 1'b1;
    end
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("rst%0d_ovalid", k), 88'(q_ovalid[k]), 88'(0));
      check($sformatf("rst%0d_ovf", k), 88'(q_ovf[k]), 88'(0));
      check($sformatf("rst%0d_str", k), q_str[k], fill(NS[k], CH_SPACE));
    end
    rstn = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NI; k++) check($sformatf("rst%0d_iready", k), 88'(q_iready[k]), 88'(1));

    foreach (tbl[i]) begin
      run_one(tbl[i].k, tbl[i].v, tbl[i].sg, tbl[i].zp, s, ov, lat);
      check($sformatf("vec%0d_str", i), s, str_of(tbl[i].s));
      check($sformatf("vec%0d_ovf", i), 88'(ov), 88'(tbl[i].ovf));
      check($sformatf("vec%0d_lat", i), 88'(lat), 88'(NS[tbl[i].k]));
    end

    // Back-pressure: the held result must not move, and a waiting request must not be taken.
    d_oready[0] = 1'b0;
    run_one(0, 32'd7, 1'b0, 1'b0, s, ov, lat);
    check("bp_first_str", s, str_of("     7"));
    d_valid[0] = 1'b1;
    d_val[0]   = 32'd8;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d_ovalid", c), 88'(q_ovalid[0]), 88'(1));
      check($sformatf("bp_hold%0d_iready", c), 88'(q_iready[0]), 88'(0));
      check($sformatf("bp_hold%0d_str", c), q_str[0], str_of("     7"));
      check($sformatf("bp_hold%0d_ovf", c), 88'(q_ovf[0]), 88'(0));
    end
    d_val[0]    = 32'd9;
    d_oready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    d_valid[0] = 1'b0;
    check("bp_release_ovalid", 88'(q_ovalid[0]), 88'(0));
    check("bp_release_iready", 88'(q_iready[0]), 88'(0));
    lat = 0;
    while (!q_ovalid[0] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("bp_next_lat", 88'(lat), 88'(6));
    check("bp_next_str", q_str[0], str_of("     9"));

    // Streaming with i_valid and o_ready both held high.
    vals[0] = 32'd1;
    vals[1] = 32'hFFFF;
    vals[2] = 32'd300;
    for (int j = 0; j < 3; j++) begin
      outs[j] = '0;
      tcyc[j] = 0;
    end
    nxt  = 0;
    nout = 0;
    @(negedge clk);
    for (int c = 0; c < 60 && nout < 3; c++) begin
      if (q_ovalid[0]) begin
        outs[nout] = q_str[0];
        tcyc[nout] = c;
        nout++;
      end
      if (q_iready[0] && nxt < 3) begin
        d_valid[0]  = 1'b1;
        d_val[0]    = vals[nxt];
        d_signed[0] = 1'b1;
        d_zpad[0]   = 1'b0;
        nxt++;
      end
      @(negedge clk);
    end
    d_valid[0] = 1'b0;
    check("stream_count", 88'(nout), 88'(3));
    for (int j = 0; j < 3; j++) begin
      model(16, 6, vals[j], 1'b1, 1'b0, s_m, ov_m);
      check($sformatf("stream%0d_str", j), outs[j], s_m);
    end
    check("stream_gap01", 88'(tcyc[1] - tcyc[0]), 88'(7));
    check("stream_gap12", 88'(tcyc[2] - tcyc[1]), 88'(7));
    check("stream_model_sanity", s_m, str_of("   300"));

    // Reset in the middle of a conversion drops the request and blanks the field.
    @(negedge clk);
    while (!q_iready[0]) @(negedge clk);
    d_valid[0]  = 1'b1;
    d_val[0]    = 32'd123;
    d_signed[0] = 1'b0;
    d_zpad[0]   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    d_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    #1 rstn = 1'b0;
    #1;
    check("midrst_ovalid", 88'(q_ovalid[0]), 88'(0));
    check("midrst_ovf", 88'(q_ovf[0]), 88'(0));
    check("midrst_str", q_str[0], fill(6, CH_SPACE));
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("midrst_iready", 88'(q_iready[0]), 88'(1));
    repeat (8) @(negedge clk);
    check("midrst_no_result", 88'(q_ovalid[0]), 88'(0));
    run_one(0, 32'd123, 1'b0, 1'b0, s, ov, lat);
    check("midrst_next_str", s, str_of("   123"));
    check("midrst_next_lat", 88'(lat), 88'(6));

    // Randomised values and modes, extremes first.
    for (int k = 0; k < NI; k++) begin
      logic [31:0] mask, msb, v;
      bit sg, zp;
      mask = (WS[k] == 32) ? 32'hFFFF_FFFF : ((32'd1 << WS[k]) - 32'd1);
      msb  = 32'd1 << (WS[k] - 1);
      for (int it = 0; it < 300; it++) begin
        if (it < 6) begin
          v  = (it / 2 == 0) ? 32'd0 : ((it / 2 == 1) ? mask : msb);
          sg = bit'(it % 2);
        end else begin
          v  = $urandom & mask;
          sg = bit'($urandom_range(0, 1));
        end
        zp = bit'($urandom_range(0, 1));
        run_one(k, v, sg, zp, s, ov, lat);
        model(WS[k], NS[k], v, sg, zp, s_m, ov_m);
        check($sformatf("rnd%0d_%0d_str v=%h s=%0d z=%0d", k, it, v, sg, zp), s, s_m);
        check($sformatf("rnd%0d_%0d_ovf", k, it), 88'(ov), 88'(ov_m));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
